// File: rtl/alu_addsub_serial_if.sv
// Start/busy/valid handshake plus operands and flags between the control unit
// and the slice-serial add/subtract unit.
interface alu_addsub_serial_if #(
    parameter int SIZE = 8
);
    logic            i_start;
    logic            i_sub;
    logic            i_cin;
    logic [SIZE-1:0] i_s1;
    logic [SIZE-1:0] i_s2;
    logic            o_busy;
    logic            o_valid;
    logic [SIZE-1:0] o_result;
    logic            o_carry;
    logic            o_overflow;
    logic            o_zero;

    modport master (
        output i_start, i_sub, i_cin, i_s1, i_s2,
        input  o_busy, o_valid, o_result, o_carry, o_overflow, o_zero
    );

    modport slave (
        input  i_start, i_sub, i_cin, i_s1, i_s2,
        output o_busy, o_valid, o_result, o_carry, o_overflow, o_zero
    );
endinterface

// File: rtl/alu_addsub_serial.sv
// Slice-serial add/subtract: SLICE bits per clock, carry held in a register
// between slices, flags and result published on entry to DONE.
module alu_addsub_serial #(
    parameter int SIZE  = 8,
    parameter int SLICE = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    alu_addsub_serial_if.slave bus
);
    localparam int N  = SIZE / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_next;
    logic [SIZE-1:0] s1_q, s2_q, acc_q, acc_next, result_q;
    logic [CW-1:0]   cnt_q;
    logic            carry_q, carry_out_q, overflow_q, zero_q;
    logic [SLICE-1:0] a_slice, b_slice;
    logic [SLICE:0]  slice_sum;
    logic            last_slice, accept, msb_cin;

    assign last_slice = (cnt_q == CW'(N - 1));
    assign accept     = bus.i_start && (state != RUN);

    // Slice select and write-back as a constant-indexed mux over all slices.
    always_comb begin
        a_slice  = '0;
        b_slice  = '0;
        acc_next = acc_q;
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) begin
                a_slice = s1_q[k*SLICE +: SLICE];
                b_slice = s2_q[k*SLICE +: SLICE];
            end
        end
        slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE{1'b0}}, carry_q};
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) acc_next[k*SLICE +: SLICE] = slice_sum[SLICE-1:0];
        end
    end

    // Carry into the top bit recovered from that bit's sum: s = a ^ b ^ cin.
    assign msb_cin = slice_sum[SLICE-1] ^ a_slice[SLICE-1] ^ b_slice[SLICE-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.i_start) state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            DONE:    state_next = bus.i_start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every slice of the accumulator is rewritten per pass, so it is not cleared on accept.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else if (accept) begin
            s1_q    <= bus.i_s1;
            s2_q    <= bus.i_sub ? ~bus.i_s2 : bus.i_s2;
            carry_q <= bus.i_cin ^ bus.i_sub;
            cnt_q   <= '0;
        end else if (state == RUN) begin
            acc_q   <= acc_next;
            carry_q <= slice_sum[SLICE];
            cnt_q   <= last_slice ? '0 : cnt_q + 1'b1;
            if (last_slice) begin
                result_q    <= acc_next;
                carry_out_q <= slice_sum[SLICE];
                overflow_q  <= msb_cin ^ slice_sum[SLICE];
                zero_q      <= (acc_next == '0);
            end
        end
    end

    assign bus.o_busy     = (state == RUN);
    assign bus.o_valid    = (state == DONE);
    assign bus.o_result   = result_q;
    assign bus.o_carry    = carry_out_q;
    assign bus.o_overflow = overflow_q;
    assign bus.o_zero     = zero_q;
endmodule

// File: tb/tb_alu_addsub_serial.sv
// Directed bench: 8-bit/2-bit-slice unit plus 16-bit units at SLICE 1, 4 and 16,
// all expected values hand-computed.
module tb_alu_addsub_serial;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_addsub_serial_if #(.SIZE(8))  if8 ();
    alu_addsub_serial_if #(.SIZE(16)) if16_1 ();
    alu_addsub_serial_if #(.SIZE(16)) if16_4 ();
    alu_addsub_serial_if #(.SIZE(16)) if16_16 ();

    alu_addsub_serial #(.SIZE(8),  .SLICE(2))  dut8     (.i_clk(clk), .i_rst(rst), .bus(if8.slave));
    alu_addsub_serial #(.SIZE(16), .SLICE(1))  dut16_1  (.i_clk(clk), .i_rst(rst), .bus(if16_1.slave));
    alu_addsub_serial #(.SIZE(16), .SLICE(4))  dut16_4  (.i_clk(clk), .i_rst(rst), .bus(if16_4.slave));
    alu_addsub_serial #(.SIZE(16), .SLICE(16)) dut16_16 (.i_clk(clk), .i_rst(rst), .bus(if16_16.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One 8-bit operation; operands are scrambled right after the accept edge.
    task automatic op8(input string tag, input logic sub, input logic cin,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] er,
                       input logic ec, input logic ev, input logic ez);
        int cyc;
        int busy_cycles;
        @(negedge clk);
        if8.i_start = 1'b1; if8.i_sub = sub; if8.i_cin = cin; if8.i_s1 = a; if8.i_s2 = b;
        @(negedge clk);
        if8.i_start = 1'b0; if8.i_sub = ~sub; if8.i_cin = ~cin; if8.i_s1 = 8'h5A; if8.i_s2 = 8'hC3;
        cyc = 1;
        busy_cycles = 0;
        while (!if8.o_valid && cyc < 12) begin
            if (if8.o_busy) busy_cycles++;
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, cyc, 5);
        check({tag, " busy cycles"}, busy_cycles, 4);
        check({tag, " busy in done"}, if8.o_busy, 1'b0);
        check({tag, " result"}, if8.o_result, er);
        check({tag, " carry"}, if8.o_carry, ec);
        check({tag, " overflow"}, if8.o_overflow, ev);
        check({tag, " zero"}, if8.o_zero, ez);
    endtask

    task automatic drive16(input logic st, input logic sub, input logic cin,
                           input logic [15:0] a, input logic [15:0] b);
        if16_1.i_start  = st; if16_1.i_sub  = sub; if16_1.i_cin  = cin; if16_1.i_s1  = a; if16_1.i_s2  = b;
        if16_4.i_start  = st; if16_4.i_sub  = sub; if16_4.i_cin  = cin; if16_4.i_s1  = a; if16_4.i_s2  = b;
        if16_16.i_start = st; if16_16.i_sub = sub; if16_16.i_cin = cin; if16_16.i_s1 = a; if16_16.i_s2 = b;
    endtask

    // Same operation on the three 16-bit units; latency expected 17, 5 and 2.
    task automatic op16(input string tag, input logic sub, input logic cin,
                        input logic [15:0] a, input logic [15:0] b, input logic [15:0] er,
                        input logic ec, input logic ev, input logic ez);
        int          lat [3];
        logic [15:0] res [3];
        logic [2:0]  fl  [3];
        int          exp_lat [3];
        exp_lat = '{17, 5, 2};
        lat = '{0, 0, 0};
        @(negedge clk);
        drive16(1'b1, sub, cin, a, b);
        @(negedge clk);
        drive16(1'b0, ~sub, ~cin, 16'h5A5A, 16'hC3C3);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (if16_1.o_valid && lat[0] == 0) begin
                lat[0] = cyc; res[0] = if16_1.o_result;
                fl[0] = {if16_1.o_carry, if16_1.o_overflow, if16_1.o_zero};
            end
            if (if16_4.o_valid && lat[1] == 0) begin
                lat[1] = cyc; res[1] = if16_4.o_result;
                fl[1] = {if16_4.o_carry, if16_4.o_overflow, if16_4.o_zero};
            end
            if (if16_16.o_valid && lat[2] == 0) begin
                lat[2] = cyc; res[2] = if16_16.o_result;
                fl[2] = {if16_16.o_carry, if16_16.o_overflow, if16_16.o_zero};
            end
            @(negedge clk);
        end
        for (int j = 0; j < 3; j++) begin
            check($sformatf("%s u%0d latency", tag, j), lat[j], exp_lat[j]);
            check($sformatf("%s u%0d result", tag, j), res[j], er);
            check($sformatf("%s u%0d c/v/z", tag, j), fl[j], {ec, ev, ez});
        end
    endtask

    initial begin
        rst = 1'b1;
        if8.i_start = 1'b0; if8.i_sub = 1'b0; if8.i_cin = 1'b0; if8.i_s1 = '0; if8.i_s2 = '0;
        drive16(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (3) @(negedge clk);
        check("reset busy", if8.o_busy, 1'b0);
        check("reset valid", if8.o_valid, 1'b0);
        check("reset result", if8.o_result, 8'h00);
        check("reset carry", if8.o_carry, 1'b0);
        check("reset overflow", if8.o_overflow, 1'b0);
        check("reset zero", if8.o_zero, 1'b0);
        rst = 1'b0;

        op8("add 7F+01",      1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
        op8("add FF+01",      1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
        op8("add 10+20+c",    1'b0, 1'b1, 8'h10, 8'h20, 8'h31, 1'b0, 1'b0, 1'b0);
        op8("sub 05-07",      1'b1, 1'b0, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0);
        op8("sub 80-01",      1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);
        op8("sub 10-0F-b",    1'b1, 1'b1, 8'h10, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b1);

        // Reset during the second RUN cycle aborts the pass and clears the flags.
        @(negedge clk);
        if8.i_start = 1'b1; if8.i_sub = 1'b0; if8.i_cin = 1'b0; if8.i_s1 = 8'h7F; if8.i_s2 = 8'h01;
        @(negedge clk);
        if8.i_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", if8.o_busy, 1'b0);
        check("abort valid", if8.o_valid, 1'b0);
        check("abort result", if8.o_result, 8'h00);
        check("abort carry", if8.o_carry, 1'b0);
        check("abort overflow", if8.o_overflow, 1'b0);
        check("abort zero", if8.o_zero, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("abort no valid c%0d", i), if8.o_valid, 1'b0);
        end
        op8("post-reset add", 1'b0, 1'b1, 8'h10, 8'h20, 8'h31, 1'b0, 1'b0, 1'b0);

        // i_start held high; only IDLE/DONE operands are taken, RUN operands are junk.
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            check($sformatf("hs valid c%0d", i), if8.o_valid, (i == 5 || i == 10 || i == 15));
            if (i == 5)  check("hs result 1", if8.o_result, 8'h03);
            if (i == 10) check("hs result 2", if8.o_result, 8'h34);
            if (i == 15) check("hs result 3", if8.o_result, 8'h45);
            if8.i_start = (i < 15);
            if8.i_sub   = 1'b0;
            if8.i_cin   = 1'b0;
            case (i)
                0:       begin if8.i_s1 = 8'h01; if8.i_s2 = 8'h02; end
                5:       begin if8.i_s1 = 8'h30; if8.i_s2 = 8'h04; end
                10:      begin if8.i_s1 = 8'h40; if8.i_s2 = 8'h05; end
                default: begin if8.i_s1 = 8'hEE; if8.i_s2 = 8'hEE; end
            endcase
        end

        op16("w16 add 7FFF+1",    1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
        op16("w16 sub 1234-1234", 1'b1, 1'b0, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1);
        op16("w16 add FFFF+0+c",  1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1);
        op16("w16 sub 0-1-b",     1'b1, 1'b1, 16'h0000, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        op16("w16 add ABCD+1234", 1'b0, 1'b0, 16'hABCD, 16'h1234, 16'hBE01, 1'b0, 1'b0, 1'b0);
        op16("w16 sub 8000-1",    1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
